// File: rtl/eq_run_pkg.sv
// Shared definitions for the equal-run stimulus generator and its detector model.
package eq_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MATCH = 2'd1,
    BREAK = 2'd2
  } state_t;

  localparam int MATCH_TARGET_DEFAULT = 4;

  localparam logic W1_IDLE = 1'b0;
  localparam logic W2_IDLE = 1'b1;

endpackage

// File: rtl/eq_run_model.sv
// Reference model of the equal-run detector: counts consecutive matching pairs
// and pulses z_exp once MATCH_TARGET of them have been seen.
module eq_run_model
  import eq_run_pkg::*;
#(
  parameter int MATCH_TARGET = MATCH_TARGET_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic w1,
  input  logic w2,
  output logic z_exp
);

  localparam int MC_W = $clog2(MATCH_TARGET + 1);
  localparam logic [MC_W-1:0] MC_MAX = MC_W'(MATCH_TARGET);

  logic [MC_W-1:0] mc_q, mc_d;
  logic            z_q;

  // The counter always clears after reaching the target, so z_exp is a single-cycle pulse.
  always_comb begin
    mc_d = mc_q + 1'b1;
    if (mc_q == MC_MAX) begin
      mc_d = '0;
    end else if (w1 != w2) begin
      mc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mc_q <= '0;
      z_q  <= 1'b0;
    end else begin
      mc_q <= mc_d;
      z_q  <= (mc_d == MC_MAX);
    end
  end

  assign z_exp = z_q;

endmodule

// File: rtl/eq_run_gen.sv
// Burst generator for the equal-run detector: run_len matching pairs, then
// gap_len mismatching pairs, with a lockstep model of the detector output.
module eq_run_gen
  import eq_run_pkg::*;
#(
  parameter int LEN_W        = 4,
  parameter int MATCH_TARGET = MATCH_TARGET_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic             w1_seed,
  output logic             w1,
  output logic             w2,
  output logic             busy,
  output logic             done,
  output logic             z_exp
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] run_cnt_q, run_cnt_d;
  logic [LEN_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             w1_q, w1_d;
  logic             w2_q, w2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Counters hold the number of pairs still to emit after the one being driven now.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    gap_cnt_d = gap_cnt_q;
    w1_d      = W1_IDLE;
    w2_d      = W2_IDLE;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          run_cnt_d = run_len;
          gap_cnt_d = gap_len;
          if (run_len != '0) begin
            state_d   = MATCH;
            run_cnt_d = run_len - ONE;
            w1_d      = w1_seed;
            w2_d      = w1_seed;
            busy_d    = 1'b1;
          end else if (gap_len != '0) begin
            state_d   = BREAK;
            gap_cnt_d = gap_len - ONE;
            w1_d      = w1_seed;
            w2_d      = ~w1_seed;
            busy_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      MATCH: begin
        if (run_cnt_q != '0) begin
          run_cnt_d = run_cnt_q - ONE;
          w1_d      = ~w1_q;
          w2_d      = ~w1_q;
          busy_d    = 1'b1;
        end else if (gap_cnt_q != '0) begin
          state_d   = BREAK;
          gap_cnt_d = gap_cnt_q - ONE;
          w1_d      = ~w1_q;
          w2_d      = w1_q;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      BREAK: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - ONE;
          w1_d      = ~w1_q;
          w2_d      = w1_q;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      run_cnt_q <= '0;
      gap_cnt_q <= '0;
      w1_q      <= W1_IDLE;
      w2_q      <= W2_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  eq_run_model #(
    .MATCH_TARGET(MATCH_TARGET)
  ) u_model (
    .clk  (clk),
    .reset(reset),
    .w1   (w1_q),
    .w2   (w2_q),
    .z_exp(z_exp)
  );

  assign w1   = w1_q;
  assign w2   = w2_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_eq_run_gen.sv
// Directed bench for eq_run_gen; each check compares {w1,w2,busy,done,z_exp}.
module tb_eq_run_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] run_len;
  logic [3:0] gap_len;
  logic       w1_seed;
  logic       w1, w2, busy, done, z_exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eq_run_gen #(
    .LEN_W(4),
    .MATCH_TARGET(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .run_len(run_len),
    .gap_len(gap_len),
    .w1_seed(w1_seed),
    .w1     (w1),
    .w2     (w2),
    .busy   (busy),
    .done   (done),
    .z_exp  (z_exp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {w1, w2, busy, done, z_exp};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed w1w2/busy/done/z=%b expected %b", tag, obs, exp);
    end
  endtask

  // Check the current cycle, then advance to the next one.
  task automatic expc(input string tag, input logic [4:0] exp);
    chk(tag, exp);
    tick();
  endtask

  // Present a request for the edge ending the current cycle; returns in cycle k+1.
  task automatic burst(input logic [3:0] r, input logic [3:0] g, input logic s);
    run_len = r;
    gap_len = g;
    w1_seed = s;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; run_len = '0; gap_len = '0; w1_seed = 1'b0;
    tick(); tick();
    reset = 1'b0;
    expc("reset_state", 5'b01000);

    // run 4, gap 0, seed 1
    burst(4'd4, 4'd0, 1'b1);
    expc("r4_k1", 5'b11100);
    expc("r4_k2", 5'b00100);
    expc("r4_k3", 5'b11100);
    expc("r4_k4", 5'b00100);
    expc("r4_k5_done_z", 5'b01011);
    chk("r4_k6_idle", 5'b01000);

    // run 9, seed 0: z pulses at k+5 and k+10
    burst(4'd9, 4'd0, 1'b0);
    expc("r9_k1", 5'b00100);
    expc("r9_k2", 5'b11100);
    expc("r9_k3", 5'b00100);
    expc("r9_k4", 5'b11100);
    expc("r9_k5_z", 5'b00101);
    expc("r9_k6", 5'b11100);
    expc("r9_k7", 5'b00100);
    expc("r9_k8", 5'b11100);
    expc("r9_k9", 5'b00100);
    expc("r9_k10_done_z", 5'b01011);
    chk("r9_k11_idle", 5'b01000);

    // run 3, gap 2, seed 1
    burst(4'd3, 4'd2, 1'b1);
    expc("r3g2_k1", 5'b11100);
    expc("r3g2_k2", 5'b00100);
    expc("r3g2_k3", 5'b11100);
    expc("r3g2_k4", 5'b01100);
    expc("r3g2_k5", 5'b10100);
    expc("r3g2_k6_done", 5'b01010);
    chk("r3g2_k7_idle", 5'b01000);

    // zero lengths, then start accepted in the done cycle with gap 1
    burst(4'd0, 4'd0, 1'b1);
    chk("r0g0_k1_done", 5'b01010);
    burst(4'd0, 4'd1, 1'b1);
    expc("r0g1_k1", 5'b10100);
    expc("r0g1_k2_done", 5'b01010);
    chk("r0g1_k3_idle", 5'b01000);

    // run 6, gap 3, seed 0 with an ignored second start at k+2
    burst(4'd6, 4'd3, 1'b0);
    expc("ign_k1", 5'b00100);
    chk("ign_k2", 5'b11100);
    run_len = 4'd1; gap_len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    expc("ign_k3", 5'b00100);
    expc("ign_k4", 5'b11100);
    expc("ign_k5_z", 5'b00101);
    expc("ign_k6", 5'b11100);
    expc("ign_k7", 5'b01100);
    expc("ign_k8", 5'b10100);
    expc("ign_k9", 5'b01100);
    expc("ign_k10_done", 5'b01010);
    chk("ign_k11_idle", 5'b01000);

    // run 15, seed 1: longest run, z at k+5, k+10, k+15
    burst(4'd15, 4'd0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      logic wv;
      wv = 1'b1 ^ logic'((i - 1) % 2);
      expc($sformatf("r15_k%0d", i), {wv, wv, 1'b1, 1'b0, logic'(i % 5 == 0)});
    end
    expc("r15_k16_done", 5'b01010);

    // reset mid-burst at edge k+3
    burst(4'd8, 4'd0, 1'b1);
    expc("rst_k1", 5'b11100);
    expc("rst_k2", 5'b00100);
    chk("rst_k3", 5'b11100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expc("rst_k4_cleared", 5'b01000);
    chk("rst_k5_no_done", 5'b01000);

    // behaves as after power-up
    burst(4'd4, 4'd0, 1'b1);
    expc("post_k1", 5'b11100);
    expc("post_k2", 5'b00100);
    expc("post_k3", 5'b11100);
    expc("post_k4", 5'b00100);
    expc("post_k5_done_z", 5'b01011);
    chk("post_k6_idle", 5'b01000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
